// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU op-codes and the accumulator controller FSM encoding.
// Imported by both the button encoder and calc_accum_ctrl.
package calc_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-sample debouncer and rising-edge
// press detector. btn_pulse is high for one cycle when btn_lvl goes 0->1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_lvl,
    output logic btn_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts consecutive synchronised samples that disagree with btn_lvl;
    // a single agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            cnt_q     <= '0;
            btn_lvl   <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so sync_q2 and the counter see pre-edge values.
            sync_q1   <= btn_raw;
            sync_q2   <= sync_q1;
            btn_pulse <= 1'b0;
            if (sync_q2 == btn_lvl) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q     <= '0;
                btn_lvl   <= sync_q2;
                btn_pulse <= sync_q2;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_accum_ctrl.sv
// Calculator accumulator controller: debounced execute/clear buttons drive a
// single-shot ALU update of a DATA_W accumulator. Optional CALC_OVF_FLAG_EN adds ovf.
module calc_accum_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btnc,
    input  logic              btnu,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] sw,
    output logic [DATA_W-1:0] led,
`ifdef CALC_OVF_FLAG_EN
    output logic              ovf,
`endif
    output logic              done
);

    localparam int MSB = DATA_W - 1;

    logic              btnc_lvl;
    logic              btnc_pulse;
    logic              btnu_lvl_unused;
    logic              btnu_pulse;

    state_t            state_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        shamt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnc (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btnc),
        .btn_lvl   (btnc_lvl),
        .btn_pulse (btnc_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnu (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btnu),
        .btn_lvl   (btnu_lvl_unused),
        .btn_pulse (btnu_pulse)
    );

    assign shamt = b_q[3:0];
    assign led   = acc_q;

    always_comb begin
        // NOTE: default first so every op code assigns alu_res and no latch is inferred.
        alu_res = acc_q;
        case (op_q)
            OP_AND:  alu_res = acc_q & b_q;
            OP_OR:   alu_res = acc_q | b_q;
            OP_ADD:  alu_res = acc_q + b_q;
            OP_SUB:  alu_res = acc_q - b_q;
            OP_SLT: begin
                alu_res    = '0;
                alu_res[0] = ($signed(acc_q) < $signed(b_q));
            end
            OP_SRL:  alu_res = acc_q >> shamt;
            OP_SLL:  alu_res = acc_q << shamt;
            OP_SRA:  alu_res = $signed(acc_q) >>> shamt;
            OP_NOR:  alu_res = ~(acc_q | b_q);
            OP_NAND: alu_res = ~(acc_q & b_q);
            OP_XOR:  alu_res = acc_q ^ b_q;
            default: alu_res = acc_q;
        endcase
    end

`ifdef CALC_OVF_FLAG_EN
    logic ovf_next;

    // Two's-complement overflow: result sign disagrees with what the operand signs force.
    always_comb begin
        ovf_next = 1'b0;
        if (op_q == OP_ADD) begin
            ovf_next = (acc_q[MSB] == b_q[MSB]) && (alu_res[MSB] != acc_q[MSB]);
        end else if (op_q == OP_SUB) begin
            ovf_next = (acc_q[MSB] != b_q[MSB]) && (alu_res[MSB] != acc_q[MSB]);
        end
    end
`endif

    // Clear has priority over every state, so a clear during EXEC drops the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_AND;
            b_q     <= '0;
            acc_q   <= '0;
            done    <= 1'b0;
`ifdef CALC_OVF_FLAG_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (btnu_pulse) begin
                state_q <= IDLE;
                acc_q   <= '0;
`ifdef CALC_OVF_FLAG_EN
                ovf     <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (btnc_pulse) begin
                            op_q    <= alu_op;
                            b_q     <= sw;
                            state_q <= EXEC;
                        end
                    end
                    EXEC: begin
                        acc_q   <= alu_res;
                        done    <= 1'b1;
`ifdef CALC_OVF_FLAG_EN
                        ovf     <= ovf_next;
`endif
                        state_q <= WAIT_REL;
                    end
                    WAIT_REL: begin
                        if (!btnc_lvl) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
